// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the traffic sensor conditioning path.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2,
    FAULT  = 2'd3
  } emgcy_state_t;

  localparam int SYNC_STAGES_DEF       = 2;
  localparam int DEBOUNCE_CYCLES_DEF   = 4;
  localparam int EMGCY_HOLD_CYCLES_DEF = 8;
  localparam int EMGCY_MAX_CYCLES_DEF  = 64;

endpackage

// File: rtl/sensor_debounce.sv
// Synchronizer chain followed by a stable-count debouncer for one raw detector input.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          stable_cnt;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Counter only runs while the synchronized input disagrees with the debounced level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level      <= 1'b0;
      stable_cnt <= '0;
    end else if (sync_out == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      level      <= ~level;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_sensor_cond.sv
// Conditions the raw EW and emergency detectors into the controller's request inputs.
//
// state  | meaning
// IDLE   | no emergency request
// ACTIVE | debounced emergency present, stuck timer running
// HOLD   | emergency dropped, minimum preemption hold running
// FAULT  | detector stuck; preemption forced until reset
module traffic_sensor_cond
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES       = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int EMGCY_HOLD_CYCLES = EMGCY_HOLD_CYCLES_DEF,
  parameter int EMGCY_MAX_CYCLES  = EMGCY_MAX_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ew_sensor_raw,
  input  logic emgcy_raw,
  input  logic ew_clear,
  output logic ew_sensor,
  output logic emgcy_sensor,
  output logic emgcy_fault
);

  localparam int AW = (EMGCY_MAX_CYCLES > 1) ? $clog2(EMGCY_MAX_CYCLES) : 1;
  localparam int HW = (EMGCY_HOLD_CYCLES > 1) ? $clog2(EMGCY_HOLD_CYCLES) : 1;
  localparam logic [AW-1:0] ACT_LAST  = AW'(EMGCY_MAX_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(EMGCY_HOLD_CYCLES - 1);

  logic ew_db;
  logic emgcy_db;

  emgcy_state_t  state_q, state_d;
  logic [AW-1:0] act_cnt_q, act_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  sensor_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ew_db (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (ew_sensor_raw),
    .level   (ew_db)
  );

  sensor_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_emgcy_db (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (emgcy_raw),
    .level   (emgcy_db)
  );

  // A vehicle still present re-asserts the request even while EW is being served.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ew_sensor <= 1'b0;
    end else begin
      ew_sensor <= ew_db | (ew_sensor & ~ew_clear);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      act_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      emgcy_sensor <= 1'b0;
      emgcy_fault  <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_cnt_q    <= act_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      emgcy_sensor <= (state_d != IDLE);
      emgcy_fault  <= (state_d == FAULT);
    end
  end

  // Detector dropping is checked before the stuck limit so a timely release goes to HOLD.
  always_comb begin
    state_d    = state_q;
    act_cnt_d  = act_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (emgcy_db) begin
          state_d   = ACTIVE;
          act_cnt_d = '0;
        end
      end
      ACTIVE: begin
        if (!emgcy_db) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LAST;
        end else if (act_cnt_q == ACT_LAST) begin
          state_d = FAULT;
        end else begin
          act_cnt_d = act_cnt_q + AW'(1);
        end
      end
      HOLD: begin
        if (emgcy_db) begin
          state_d   = ACTIVE;
          act_cnt_d = '0;
        end else if (hold_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
